// File: rtl/serial_pkg.sv
// Shared definitions for the serial link.
// Line levels and states are common to TX and RX.
package serial_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  // Width of a counter holding 0..n-1, never below 1 bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/serial_tx_bit_timer.sv
// Bit period timer: counts clocks within one line bit.
// tick marks the last cycle, tick_next foretells it.
module bit_timer #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic CLK,
  input  logic RST,
  input  logic clear,
  output logic tick,
  output logic tick_next
);
  import serial_pkg::*;

  localparam int CW = cnt_w(CLKS_PER_BIT);
  localparam int PRE_I =
    (CLKS_PER_BIT > 1) ? CLKS_PER_BIT - 2 : 0;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] PRE  = CW'(PRE_I);
  localparam logic ONE_CLK = (CLKS_PER_BIT == 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign tick = (cnt_q == LAST);

  // A wrap or clear restarts at 0, which is the last
  // cycle only when a bit lasts a single clock.
  assign tick_next = (clear || tick) ? ONE_CLK
                                     : (cnt_q == PRE);

  // Next count: restart on clear or bit boundary.
  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (clear || tick) begin
      cnt_d = '0;
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/serial_tx.sv
// Framed serial transmitter: start, data LSB first, stop.
// All outputs are flops; the line idles high.
module serial_tx #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [DATA_W-1:0] data_in,
  input  logic              valid,
  output logic              ready,
  output logic              tx,
  output logic              busy,
  output logic              done
);
  import serial_pkg::*;

  localparam int BW = $clog2(DATA_W + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

  tx_state_t state_q;
  tx_state_t state_d;

  logic tx_q;
  logic tx_d;
  logic ready_q;
  logic ready_d;
  logic busy_q;
  logic busy_d;
  logic done_q;
  logic done_d;

  logic [DATA_W-1:0] shreg_q;
  logic [DATA_W-1:0] shreg_d;
  logic [BW-1:0]     bit_q;
  logic [BW-1:0]     bit_d;

  logic timer_clr;
  logic tick;
  logic tick_next;

  // Hold the timer at 0 while idle so a frame starts fresh.
  assign timer_clr = (state_q == IDLE);

  bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_timer (
    .CLK      (CLK),
    .RST      (RST),
    .clear    (timer_clr),
    .tick     (tick),
    .tick_next(tick_next)
  );

  // Next state and next registered outputs.
  always_comb begin
    state_d = state_q;
    tx_d    = tx_q;
    ready_d = ready_q;
    busy_d  = busy_q;
    shreg_d = shreg_q;
    bit_d   = bit_q;

    unique case (state_q)
      IDLE: begin
        tx_d    = LINE_IDLE;
        ready_d = 1'b1;
        busy_d  = 1'b0;
        bit_d   = '0;
        if (valid && ready_q) begin
          state_d = START;
          shreg_d = data_in;
          tx_d    = START_BIT;
          ready_d = 1'b0;
          busy_d  = 1'b1;
        end
      end
      START: begin
        if (tick) begin
          state_d = DATA;
          tx_d    = shreg_q[0];
        end
      end
      DATA: begin
        if (tick) begin
          shreg_d = shreg_q >> 1;
          bit_d   = bit_q + BW'(1);
          if (bit_q == LAST_BIT) begin
            state_d = STOP;
            tx_d    = STOP_BIT;
          end else begin
            tx_d = shreg_d[0];
          end
        end
      end
      STOP: begin
        if (tick) begin
          state_d = IDLE;
          tx_d    = LINE_IDLE;
          ready_d = 1'b1;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = LINE_IDLE;
        ready_d = 1'b1;
        busy_d  = 1'b0;
      end
    endcase

    // done is registered, so raise it one cycle ahead:
    // when the coming cycle is the last stop cycle.
    done_d = (state_d == STOP) && tick_next;
  end

  // FSM, datapath and output registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      tx_q    <= LINE_IDLE;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      shreg_q <= '0;
      bit_q   <= '0;
    end else begin
      state_q <= state_d;
      tx_q    <= tx_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      shreg_q <= shreg_d;
      bit_q   <= bit_d;
    end
  end

  assign tx    = tx_q;
  assign ready = ready_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule
